// File: rtl/bcd_display_driver.sv
// Binary-to-BCD converter (sequential double-dabble) feeding a 4-digit multiplexed 7-segment display.
// Optional macro LEADING_ZERO_BLANK_EN blanks leading zeros above the decimal-point digit.
module bcd_display_driver #(
    parameter int REFRESH_DIV = 100000,
    parameter int DP_POS      = 3
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [15:0] value,
    input  logic        load,
    output logic        busy,
    output logic [15:0] bcd,
    output logic        ovf,
    output logic [6:0]  seg,
    output logic        dp,
    output logic [3:0]  an
);
    localparam int RW = (REFRESH_DIV > 2) ? $clog2(REFRESH_DIV) : 1;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_t;

    state_t          state_r;
    logic [15:0]     bin_r;
    logic [15:0]     work_r;
    logic [3:0]      cnt_r;
    logic            ovf_pend_r;
    logic [RW-1:0]   refresh_r;
    logic [1:0]      digit_r;

    logic [15:0]     adj_s;
    logic [3:0]      digit_val_s;
    logic            blank_s;
    logic [6:0]      seg_s;
    logic            dp_s;
    logic [3:0]      an_s;

    // Add 3 to every BCD nibble that is 5 or more, ahead of the next shift
    function automatic logic [15:0] dabble_adjust(input logic [15:0] d);
        logic [15:0] r;
        r = d;
        for (int i = 0; i < 4; i++) begin
            if (d[i*4 +: 4] >= 4'd5) begin
                r[i*4 +: 4] = d[i*4 +: 4] + 4'd3;
            end else begin
                r[i*4 +: 4] = d[i*4 +: 4];
            end
        end
        return r;
    endfunction

    // Active-low segment pattern, bit order g..a
    function automatic logic [6:0] seg_decode(input logic [3:0] d);
        logic [6:0] s;
        case (d)
            4'd0:    s = 7'h40;
            4'd1:    s = 7'h79;
            4'd2:    s = 7'h24;
            4'd3:    s = 7'h30;
            4'd4:    s = 7'h19;
            4'd5:    s = 7'h12;
            4'd6:    s = 7'h02;
            4'd7:    s = 7'h78;
            4'd8:    s = 7'h00;
            4'd9:    s = 7'h10;
            default: s = 7'h7F;
        endcase
        return s;
    endfunction

    // Conversion datapath: adjust the current BCD accumulator before shifting
    always_comb begin
        adj_s = dabble_adjust(work_r);
    end

    // Conversion FSM; bcd/ovf only change on the DONE step so partial results never escape
    always_ff @(posedge clk) begin
        if (reset) begin
            state_r    <= IDLE;
            busy       <= 1'b0;
            bcd        <= 16'h0000;
            ovf        <= 1'b0;
            bin_r      <= 16'd0;
            work_r     <= 16'd0;
            cnt_r      <= 4'd0;
            ovf_pend_r <= 1'b0;
        end else begin
            case (state_r)
                IDLE: begin
                    if (load) begin
                        bin_r      <= (value > 16'd9999) ? 16'd9999 : value;
                        ovf_pend_r <= (value > 16'd9999);
                        work_r     <= 16'd0;
                        cnt_r      <= 4'd0;
                        state_r    <= SHIFT;
                        busy       <= 1'b1;
                    end else begin
                        state_r    <= IDLE;
                        busy       <= 1'b0;
                    end
                end
                SHIFT: begin
                    work_r <= {adj_s[14:0], bin_r[15]};
                    bin_r  <= {bin_r[14:0], 1'b0};
                    cnt_r  <= cnt_r + 4'd1;
                    if (cnt_r == 4'd15) begin
                        state_r <= DONE;
                    end else begin
                        state_r <= SHIFT;
                    end
                end
                DONE: begin
                    bcd     <= work_r;
                    ovf     <= ovf_pend_r;
                    state_r <= IDLE;
                    busy    <= 1'b0;
                end
                default: begin
                    state_r <= IDLE;
                    busy    <= 1'b0;
                end
            endcase
        end
    end

    // Display decode for the currently selected digit, including optional blanking
    always_comb begin
        digit_val_s = bcd[{digit_r, 2'b00} +: 4];
        blank_s     = 1'b0;
`ifdef LEADING_ZERO_BLANK_EN
        if (int'(digit_r) > DP_POS) begin
            case (digit_r)
                2'd1:    blank_s = (bcd[15:4] == 12'd0);
                2'd2:    blank_s = (bcd[15:8] == 8'd0);
                2'd3:    blank_s = (bcd[15:12] == 4'd0);
                default: blank_s = 1'b0;
            endcase
        end else begin
            blank_s = 1'b0;
        end
`endif
        if (blank_s) begin
            seg_s = 7'h7F;
            dp_s  = 1'b1;
        end else begin
            seg_s = seg_decode(digit_val_s);
            dp_s  = (int'(digit_r) == DP_POS) ? 1'b0 : 1'b1;
        end
        an_s = ~(4'b0001 << digit_r);
    end

    // Refresh timebase, digit scan and registered display outputs
    always_ff @(posedge clk) begin
        if (reset) begin
            refresh_r <= '0;
            digit_r   <= 2'd0;
            an        <= 4'b1110;
            seg       <= 7'h40;
            dp        <= (DP_POS == 0) ? 1'b0 : 1'b1;
        end else begin
            if (refresh_r == RW'(REFRESH_DIV - 1)) begin
                refresh_r <= '0;
                digit_r   <= digit_r + 2'd1;
            end else begin
                refresh_r <= refresh_r + 1'b1;
                digit_r   <= digit_r;
            end
            an  <= an_s;
            seg <= seg_s;
            dp  <= dp_s;
        end
    end
endmodule

// File: tb/tb_bcd_display_driver.sv
// Directed bench for bcd_display_driver: scoreboard on conversion results plus display-scan checks.
module tb_bcd_display_driver;
    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic [15:0] value = 16'd0;
    logic        load = 1'b0;
    logic        busy, ovf, dp;
    logic [15:0] bcd;
    logic [6:0]  seg;
    logic [3:0]  an;
    logic        busy2, ovf2, dp2;
    logic [15:0] bcd2;
    logic [6:0]  seg2;
    logic [3:0]  an2;

    int checks = 0;
    int errors = 0;
    logic [16:0] sb[$];
    logic busy_prev = 1'b0;

    always #5 clk = ~clk;

    bcd_display_driver #(.REFRESH_DIV(4), .DP_POS(3)) dut (
        .clk(clk), .reset(reset), .value(value), .load(load), .busy(busy),
        .bcd(bcd), .ovf(ovf), .seg(seg), .dp(dp), .an(an)
    );

    bcd_display_driver #(.REFRESH_DIV(4), .DP_POS(0)) dut2 (
        .clk(clk), .reset(reset), .value(value), .load(load), .busy(busy2),
        .bcd(bcd2), .ovf(ovf2), .seg(seg2), .dp(dp2), .an(an2)
    );

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    function automatic logic [6:0] seg_ref(input logic [3:0] d);
        case (d)
            4'd0: return 7'h40;  4'd1: return 7'h79;  4'd2: return 7'h24;
            4'd3: return 7'h30;  4'd4: return 7'h19;  4'd5: return 7'h12;
            4'd6: return 7'h02;  4'd7: return 7'h78;  4'd8: return 7'h00;
            4'd9: return 7'h10;  default: return 7'h7F;
        endcase
    endfunction

    function automatic logic blank_ref(input logic [15:0] b, input int d, input int dpp);
`ifdef LEADING_ZERO_BLANK_EN
        if (d == 0 || d <= dpp) return 1'b0;
        return ((b >> (4 * d)) == 16'd0);
`else
        return 1'b0;
`endif
    endfunction

    // Scoreboard: a completed conversion is marked by busy falling outside reset
    always @(negedge clk) begin
        if (busy_prev && !busy && !reset) begin
            if (sb.size() == 0) begin
                chk("sb_underflow", 16'(sb.size()), 16'd1);
            end else begin
                logic [16:0] e;
                e = sb.pop_front();
                chk("sb_bcd", bcd, e[15:0]);
                chk("sb_ovf", {15'd0, ovf}, {15'd0, e[16]});
                chk("sb_bcd_dut2", bcd2, e[15:0]);
            end
        end
        busy_prev = busy;
    end

    // Called at a negedge; the load is sampled by the next rising edge
    task automatic pulse(input logic [15:0] v, input bit push, input logic [15:0] eb, input logic eo);
        value = v;
        load = 1'b1;
        if (push) sb.push_back({eo, eb});
        @(negedge clk);
        load = 1'b0;
    endtask

    task automatic wait_idle();
        int n = 0;
        while (busy !== 1'b0 && n < 100) begin
            @(negedge clk);
            n++;
        end
        chk("idle_timeout", 16'(n < 100), 16'd1);
    endtask

    task automatic check_display(input logic [15:0] b);
        logic [3:0] prev;
        int n = 0;
        prev = an;
        @(negedge clk);
        while (!(prev == 4'b0111 && an == 4'b1110) && n < 40) begin
            prev = an;
            @(negedge clk);
            n++;
        end
        chk("scan_sync", 16'(n < 40), 16'd1);
        for (int c = 0; c < 16; c++) begin
            int d;
            logic bl1, bl2;
            d = c / 4;
            bl1 = blank_ref(b, d, 3);
            bl2 = blank_ref(b, d, 0);
            chk("an", {12'd0, an}, {12'd0, ~(4'b0001 << d)});
            chk("seg", {9'd0, seg}, {9'd0, bl1 ? 7'h7F : seg_ref(b[4*d +: 4])});
            chk("dp", {15'd0, dp}, {15'd0, (bl1 || d != 3)});
            chk("an2", {12'd0, an2}, {12'd0, ~(4'b0001 << d)});
            chk("seg2", {9'd0, seg2}, {9'd0, bl2 ? 7'h7F : seg_ref(b[4*d +: 4])});
            chk("dp2", {15'd0, dp2}, {15'd0, (bl2 || d != 0)});
            @(negedge clk);
        end
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        bit seen;
        repeat (3) @(negedge clk);
        chk("rst_busy", {15'd0, busy}, 16'd0);
        chk("rst_bcd", bcd, 16'h0000);
        chk("rst_ovf", {15'd0, ovf}, 16'd0);
        chk("rst_an", {12'd0, an}, 16'h000E);
        chk("rst_seg", {9'd0, seg}, 16'h0040);
        chk("rst_dp", {15'd0, dp}, 16'd1);
        chk("rst_dp2", {15'd0, dp2}, 16'd0);
        reset = 1'b0;
        @(negedge clk);

        // 3300: busy exactly 17 cycles
        pulse(16'd3300, 1'b1, 16'h3300, 1'b0);
        n = 0;
        while (busy === 1'b1 && n < 40) begin
            n++;
            @(negedge clk);
        end
        chk("busy_len", 16'(n), 16'd17);
        @(negedge clk);

        // Overflow saturates, then a zero clears ovf
        pulse(16'd12000, 1'b1, 16'h9999, 1'b1);
        wait_idle();
        pulse(16'd0, 1'b1, 16'h0000, 1'b0);
        wait_idle();
        pulse(16'd9999, 1'b1, 16'h9999, 1'b0);
        wait_idle();
        pulse(16'd10000, 1'b1, 16'h9999, 1'b1);
        wait_idle();

        // Load while busy is dropped; load 18 cycles after the first is accepted
        pulse(16'd42, 1'b1, 16'h0042, 1'b0);
        repeat (4) @(negedge clk);
        pulse(16'd1234, 1'b0, 16'h0000, 1'b0);
        repeat (12) @(negedge clk);
        chk("b2b_idle", {15'd0, busy}, 16'd0);
        pulse(16'd1234, 1'b1, 16'h1234, 1'b0);
        chk("b2b_busy", {15'd0, busy}, 16'd1);
        wait_idle();
        @(negedge clk);

        // Display scan
        pulse(16'd1208, 1'b1, 16'h1208, 1'b0);
        wait_idle();
        check_display(16'h1208);
        pulse(16'd7, 1'b1, 16'h0007, 1'b0);
        wait_idle();
        check_display(16'h0007);

        // Reset in the middle of converting 5678
        pulse(16'd5678, 1'b1, 16'h5678, 1'b0);
        repeat (7) @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        void'(sb.pop_back());
        chk("abort_busy", {15'd0, busy}, 16'd0);
        chk("abort_bcd", bcd, 16'h0000);
        chk("abort_an", {12'd0, an}, 16'h000E);
        chk("abort_seg", {9'd0, seg}, 16'h0040);
        @(negedge clk);
        reset = 1'b0;
        seen = 1'b0;
        for (int i = 0; i < 30; i++) begin
            if (bcd === 16'h5678 || busy !== 1'b0) seen = 1'b1;
            @(negedge clk);
        end
        chk("no_partial", {15'd0, seen}, 16'd0);
        chk("sb_empty", 16'(sb.size()), 16'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/bcd_display_driver.md
BCD_DISPLAY_DRIVER -- requirements
Module: bcd_display_driver

Interface
REQ-001 SHALL have parameter REFRESH_DIV, default 100000: clocks per digit slot (1 ms at 100 MHz); legal range 2 or more.
REQ-002 SHALL have parameter DP_POS, default 3: digit index (0..3) that lights the decimal point; 3 gives X.XXX volts.
REQ-003 SHALL have port clk, input, 1 bit: single clock; all logic on its rising edge.
REQ-004 SHALL have port reset, input, 1 bit: synchronous, active-high.
REQ-005 SHALL have port value, input, 16 bits: unsigned scaled ADC result in millivolts.
REQ-006 SHALL have port load, input, 1 bit: one-cycle strobe qualifying value.
REQ-007 SHALL have port busy, output, 1 bit: high while a conversion is in progress.
REQ-008 SHALL have port bcd, output, 16 bits: four packed BCD digits, [15:12] = digit 3 (most significant).
REQ-009 SHALL have port ovf, output, 1 bit: last converted value exceeded 9999.
REQ-010 SHALL have port seg, output, 7 bits: active-low segments, [6:0] = g..a.
REQ-011 SHALL have port dp, output, 1 bit: active-low decimal point.
REQ-012 SHALL have port an, output, 4 bits: active-low, one-hot digit enables.

Function
REQ-013 SHALL implement FSM states IDLE, SHIFT and DONE.
- IDLE -> SHIFT on load.
- SHIFT runs exactly 16 cycles, then -> DONE.
- DONE -> IDLE unconditionally.
REQ-014 SHALL, in IDLE with load=1 at edge k, capture min(value, 9999) and capture ovf_next = (value > 9999).
REQ-015 SHALL convert by sequential double-dabble, one bit per SHIFT cycle: add 3 to any nibble of 5 or more, then shift left.
REQ-016 SHALL update bcd and ovf together at edge k+17; both hold their values between updates.
REQ-017 SHALL keep busy = (state != IDLE), i.e. high for exactly 17 cycles per accepted load.
REQ-018 SHALL ignore load while busy; no queuing, and the in-flight conversion is unaffected.
REQ-019 SHALL accept a load that arrives in the same cycle the FSM returns to IDLE (back-to-back period of 18 cycles).
REQ-020 SHALL run a refresh counter 0..REFRESH_DIV-1; on wrap, the digit index advances 0->1->2->3->0.
REQ-021 SHALL drive an[i] = 0 only for the current digit index i; seg decodes bcd digit i using the standard 0-9 table.
REQ-022 SHALL drive dp = 0 only when the current digit index equals DP_POS.
REQ-023 SHALL keep the display path independent of the FSM; display output changes only after bcd updates.

Reset
REQ-024 SHALL, on reset, set:
- state = IDLE, busy = 0;
- bcd = 16'h0000, ovf = 0;
- refresh counter = 0, digit index = 0;
- an = 4'b1110, seg showing "0", dp per REQ-022.
REQ-025 SHALL abort a conversion when reset is asserted mid-conversion; no partial result reaches bcd.

Configuration
REQ-026 With macro LEADING_ZERO_BLANK_EN defined:
- digit i (1..3) SHALL be blanked (seg = 7'h7F, dp = 1) when i > DP_POS and digits i..3 are all zero;
- digit 0 SHALL never be blanked.
REQ-027 Without LEADING_ZERO_BLANK_EN, all four digits SHALL always be displayed.

Verification
REQ-028 value=3300, load pulse at edge k -> busy high for edges k+1..k+17; bcd=16'h3300, ovf=0 at edge k+17.
REQ-029 value=12000 -> bcd=16'h9999, ovf=1; a following value=0 -> bcd=16'h0000, ovf=0.
REQ-030 Second load (value=1234) 5 cycles after the first (value=42) -> dropped; bcd=16'h0042. A load exactly 18 cycles after the first -> accepted; bcd=16'h1234.
REQ-031 Reset asserted at SHIFT cycle 8 of value=5678 -> bcd=0 and busy=0 next cycle; no 5678 ever appears.
REQ-032 REFRESH_DIV=4, bcd=16'h1208, DP_POS=3 -> an cycles 1110, 1101, 1011, 0111 every 4 clocks; seg = 8, 0, 2, 1; dp low only on digit 3.
REQ-033 With LEADING_ZERO_BLANK_EN, DP_POS=0, value=7 -> digits 3..1 blank, digit 0 shows 7; with DP_POS=3 -> displays 0007.
